// File: rtl/systolic_skew_feeder.sv
// Skews one LANES-wide row per handshake into a diagonal wavefront for a MAC array.
// Optional SKEW_REVERSE_EN adds cfg_reverse, which mirrors the skew for output de-skew.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clock,
    input  logic                        reset,
`ifdef SKEW_REVERSE_EN
    input  logic                        cfg_reverse,
`endif
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]            out_lane_valid,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((LANES > 1) ? LANES - 2 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            adv, accept;
    logic [LANES-1:0] lane_v, lane_l, tail;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv && (state_q != FLUSH) && !reset;
    assign accept   = in_valid && in_ready;

`ifdef SKEW_REVERSE_EN
    logic rev_q;

    // Latch the skew direction on the opening row of each frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rev_q <= 1'b0;
        else if (accept && state_q == IDLE)
            rev_q <= cfg_reverse;
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SKEW_REVERSE_EN
        localparam int DEP = LANES;
`else
        localparam int DEP = i + 1;
`endif
        logic [DATA_WIDTH-1:0] sd [DEP];
        logic [DEP-1:0]        sv;
        logic [DEP-1:0]        sl;
        logic [DATA_WIDTH-1:0] td;

        // Shift this lane's chain one stage per advance; bubbles load zeros
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int j = 0; j < DEP; j++)
                    sd[j] <= '0;
                sv <= '0;
                sl <= '0;
            end else if (adv) begin
                sd[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                sv[0] <= accept;
                sl[0] <= accept && in_last;
                for (int j = 1; j < DEP; j++) begin
                    sd[j] <= sd[j-1];
                    sv[j] <= sv[j-1];
                    sl[j] <= sl[j-1];
                end
            end
        end

`ifdef SKEW_REVERSE_EN
        logic [CW-1:0] tap;
        assign tap       = rev_q ? CW'(LANES - 1 - i) : CW'(i);
        assign td        = sd[tap];
        assign lane_v[i] = sv[tap];
        assign lane_l[i] = sl[tap];
        assign tail[i]   = rev_q ? (i == 0) : (i == LANES - 1);
`else
        assign td        = sd[i];
        assign lane_v[i] = sv[i];
        assign lane_l[i] = sl[i];
        assign tail[i]   = (i == LANES - 1);
`endif
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_v[i] ? td : '0;
        assign out_lane_valid[i] = lane_v[i];
    end

    assign out_valid = |lane_v;
    assign out_last  = |(lane_v & lane_l & tail);

    // Frame state and flush counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame sequencing: load rows, then drain with LANES-1 bubble advances
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (accept && in_last)
                    state_d = (LANES > 1) ? FLUSH : IDLE;
                else if (accept)
                    state_d = LOAD;
            end
            FLUSH: begin
                if (adv) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder, LANES=4, DATA_WIDTH=8.
// Stimulus queues expected wavefronts; a negedge monitor checks each transfer.
module tb_systolic_skew_feeder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_lane_valid;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    int tests = 0;
    int errors = 0;
    logic [36:0] exp_q [$];

    systolic_skew_feeder #(.DATA_WIDTH(8), .LANES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {27'd0, out_data, out_lane_valid, out_last}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("xfer", {27'd0, out_data, out_lane_valid, out_last}, {27'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] v, input logic l);
        exp_q.push_back({d, v, l});
    endtask

    task automatic send(input logic [31:0] row, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = row;
        in_last  = last;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready)
            chk("send_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain(input string nm, input int exp_n, input int stall_at);
        int n = 0;
        while (!in_ready && n < 20) begin
            out_ready = (n != stall_at);
            n++;
            step();
        end
        out_ready = 1'b1;
        chk(nm, 64'(n), 64'(exp_n));
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_lv", 64'(out_lane_valid), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Two-row frame, no backpressure
        push(32'h00000001, 4'b0001, 1'b0);
        push(32'h00000205, 4'b0011, 1'b0);
        push(32'h00030600, 4'b0110, 1'b0);
        push(32'h04070000, 4'b1100, 1'b0);
        push(32'h08000000, 4'b1000, 1'b1);
        send(32'h04030201, 1'b0);
        send(32'h08070605, 1'b1);
        drain("flush_len_basic", 3, -1);

        // Same frame with a two-cycle stall mid-frame
        push(32'h00000001, 4'b0001, 1'b0);
        push(32'h00000205, 4'b0011, 1'b0);
        push(32'h00030600, 4'b0110, 1'b0);
        push(32'h04070000, 4'b1100, 1'b0);
        push(32'h08000000, 4'b1000, 1'b1);
        send(32'h04030201, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h08070605;
        in_last   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_data", 64'(out_data), 64'h1);
            chk("stall_lv", 64'(out_lane_valid), 64'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("resume_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        drain("flush_len_stall", 3, -1);

        // One-row frame from IDLE, one stall inside the flush
        push(32'h00000009, 4'b0001, 1'b0);
        push(32'h00000900, 4'b0010, 1'b0);
        push(32'h00090000, 4'b0100, 1'b0);
        push(32'h09000000, 4'b1000, 1'b1);
        send(32'h09090909, 1'b1);
        drain("flush_len_onerow", 4, 1);

        // Gapped input: one bubble between rows
        push(32'h00000001, 4'b0001, 1'b0);
        push(32'h00000200, 4'b0010, 1'b0);
        push(32'h00030005, 4'b0101, 1'b0);
        push(32'h04000600, 4'b1010, 1'b0);
        push(32'h00070000, 4'b0100, 1'b0);
        push(32'h08000000, 4'b1000, 1'b1);
        send(32'h04030201, 1'b0);
        step();
        send(32'h08070605, 1'b1);
        drain("flush_len_gap", 3, -1);

        // Reset while the second row is in flight
        push(32'h00000001, 4'b0001, 1'b0);
        send(32'h04030201, 1'b0);
        send(32'h08070605, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_lv", 64'(out_lane_valid), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_last", 64'(out_last), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("after_rst_ready", 64'(in_ready), 64'd1);
        step();
        chk("after_rst_idle_valid", 64'(out_valid), 64'd0);
        chk("after_rst_idle_ready", 64'(in_ready), 64'd1);

        repeat (3) step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
